packer_left: RTL

Gathers narrow words (IN_WIDTH) from a streaming producer into wide words (OUT_WIDTH), MSB-first, and queues them in a 2-entry output buffer for the wide consumer. It sits directly upstream of the unpacker in the PE datapath. The first narrow word accepted lands in the top bits of the wide word, so a round trip through packer and unpacker restores the original word order. A flush request zero-pads and emits a partially filled wide word at the end of a tile.

---
 rtl/packer_left.sv | 117 +++++++++++
 1 files changed

// File: rtl/packer_left.sv
// Packs IN_WIDTH words MSB-first into OUT_WIDTH words and queues them in a 2-entry FIFO.
// A flush zero-pads a partially assembled word and pushes it once a FIFO slot is free.
module packer_left #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Reset,
    input  logic                 Unpacked_EnWr,
    input  logic [IN_WIDTH-1:0]  Unpacked_DatWr,
    output logic                 Unpacked_RdyWr,
    input  logic                 Flush,
    output logic                 Flush_Done,
    output logic                 Packed_ValRd,
    output logic [OUT_WIDTH-1:0] Packed_DatRd,
    input  logic                 Packed_EnRd
);
    localparam int RATIO = OUT_WIDTH / IN_WIDTH;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    logic [OUT_WIDTH-1:0] asm_q, asm_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 done_q, done_d;
    logic [OUT_WIDTH-1:0] ent_q [2];
    logic                 wr_q, rd_q;
    logic [1:0]           fcnt_q;

    logic                 acc, pop, exec, push;
    logic [OUT_WIDTH-1:0] shifted, padded, push_data;

    generate
        if (RATIO == 1) begin : g_r1
            assign shifted = Unpacked_DatWr;
        end else begin : g_rn
            assign shifted = {asm_q[OUT_WIDTH-IN_WIDTH-1:0], Unpacked_DatWr};
        end
    endgenerate

    // Valid words sit in the low cnt slots; move them up to the MSB end.
    assign padded = asm_q << ((RATIO - 32'(cnt_q)) * IN_WIDTH);

    assign Unpacked_RdyWr = !flush_pend_q && ((cnt_q != LAST) || (fcnt_q < 2'd2));
    assign acc            = Unpacked_EnWr && Unpacked_RdyWr;
    assign pop            = Packed_EnRd && (fcnt_q != 2'd0);
    assign exec           = flush_pend_q && (fcnt_q < 2'd2);

    always_comb begin
        asm_d        = asm_q;
        cnt_d        = cnt_q;
        push         = 1'b0;
        push_data    = shifted;
        flush_pend_d = flush_pend_q | Flush;
        done_d       = 1'b0;
        // acc and exec are exclusive: RdyWr is low while a flush is pending.
        if (acc) begin
            if (cnt_q == LAST) begin
                push  = 1'b1;
                cnt_d = '0;
                asm_d = '0;
            end else begin
                asm_d = shifted;
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (exec) begin
            flush_pend_d = 1'b0;
            done_d       = 1'b1;
            if (cnt_q != '0) begin
                push      = 1'b1;
                push_data = padded;
                cnt_d     = '0;
                asm_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            done_q       <= 1'b0;
            ent_q[0]     <= '0;
            ent_q[1]     <= '0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            fcnt_q       <= 2'd0;
        end else if (Reset) begin
            asm_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            done_q       <= 1'b0;
            ent_q[0]     <= '0;
            ent_q[1]     <= '0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            fcnt_q       <= 2'd0;
        end else begin
            asm_q        <= asm_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            done_q       <= done_d;
            if (push) ent_q[wr_q] <= push_data;
            wr_q   <= wr_q ^ push;
            rd_q   <= rd_q ^ pop;
            fcnt_q <= fcnt_q + 2'(push) - 2'(pop);
        end
    end

    assign Flush_Done   = done_q;
    assign Packed_ValRd = (fcnt_q != 2'd0);
    assign Packed_DatRd = ent_q[rd_q];

endmodule
